// File: rtl/pipe_ctrl_pkg.sv
// Shared front-end control types.
// State encoding and opcode constants.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [5:0] R_FORMAT = 6'h00;
  localparam logic [5:0] BEQ      = 6'h04;
  localparam logic [5:0] LW       = 6'h23;
  localparam logic [5:0] SW       = 6'h2B;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
// Holds at all ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // count up on inc, stop at the ceiling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Front-end stall/flush sequencer.
// Stretches decode hazard pulses into bubbles.
module pipeline_stall_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 3,
  parameter int LEN_W     = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             haz_req,
  input  logic [LEN_W-1:0] haz_len,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] rem_nx;
  logic [LEN_W-1:0] len;
  logic             stall_act;

  assign stall_act = (state == STALL)
                   | (state == IDLE & haz_req);

  // clamp requested length into 1..MAX_STALL
  always_comb begin
    len = haz_len;
    if (haz_len == '0) begin
      len = LEN_W'(1);
    end else if (32'(haz_len) > MAX_STALL) begin
      len = LEN_W'(MAX_STALL);
    end
  end

  // next state and remaining-bubble count
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    unique case (state)
      IDLE: begin
        if (haz_req && !mem_busy
            && len != LEN_W'(1)) begin
          state_nx = STALL;
          rem_nx   = len - LEN_W'(1);
        end
      end
      STALL: begin
        if (!mem_busy) begin
          rem_nx = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            state_nx = IDLE;
          end
        end
      end
    endcase
  end

  // state register; reset drops any stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
    end
  end

  // mem_busy beats stall, stall beats flush
  always_comb begin
    pc_hold     = ~rst & (stall_act | mem_busy);
    ifid_hold   = ~rst & (stall_act | mem_busy);
    idex_bubble = ~rst & stall_act & ~mem_busy;
    ifid_flush  = ~rst & br_taken
                & ~stall_act & ~mem_busy;
    busy        = ~rst & (state == STALL);
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (idex_bubble),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ifid_flush),
    .count (flush_cnt)
  );

endmodule
